card_deck_shuffler: RTL and testbench

//   Builds and holds the board layout for the card-matching game. It fills NCARDS

---
 rtl/card_deck_shuffler.sv | 105 ++++++++++
 tb/tb_card_deck_shuffler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_deck_shuffler.sv
// Board layout generator for the card-matching game: fills symbol pairs, then
// applies an LFSR-driven Fisher-Yates shuffle with bounded rejection sampling.
module card_deck_shuffler #(
    parameter int          NCARDS    = 16,
    parameter int          IDXW      = 4,
    parameter int          SYMW      = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_REJ   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [15:0]     seed_in,
    output logic            busy,
    output logic            done,
    input  logic [IDXW-1:0] rd_idx,
    output logic [SYMW-1:0] rd_symbol
);

    localparam int REJW = (MAX_REJ > 1) ? $clog2(MAX_REJ) : 1;

    typedef enum logic [1:0] {IDLE, FILL, SHUFFLE, DONE} state_t;

    state_t            state, state_next;
    logic [SYMW-1:0]   slots [NCARDS];
    logic [15:0]       lfsr;
    logic [IDXW-1:0]   i;
    logic [REJW-1:0]   rej;

    logic [IDXW-1:0]   r;
    logic [15:0]       lfsr_step;
    logic [15:0]       seed_mix;
    logic [15:0]       seed_load;
    logic              accept;
    logic              advance;
    logic              fill_last;

    assign r         = lfsr[IDXW-1:0];
    assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    assign seed_mix  = seed_in ^ LFSR_SEED;
    assign seed_load = (seed_mix == '0) ? LFSR_SEED : seed_mix;
    assign accept    = start && (state == IDLE || state == DONE);
    // A position retires either on an in-range draw or once the rejection budget is spent.
    assign advance   = (r <= i) || (rej == REJW'(MAX_REJ - 1));
    assign fill_last = (i == IDXW'(NCARDS - 1));
    assign rd_symbol = slots[rd_idx];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (fill_last) state_next = SHUFFLE;
            SHUFFLE: if (advance && i == IDXW'(1)) state_next = DONE;
            DONE:    if (start) state_next = FILL;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == FILL) || (state_next == SHUFFLE);
            done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NCARDS; k++) slots[k] <= '0;
            lfsr <= LFSR_SEED;
            i    <= '0;
            rej  <= '0;
        end else begin
            if (accept) begin
                lfsr <= seed_load;
                i    <= '0;
            end else if (state == FILL) begin
                slots[i] <= SYMW'(i >> 1);
                if (fill_last) begin
                    i   <= IDXW'(NCARDS - 1);
                    rej <= '0;
                end else begin
                    i <= i + IDXW'(1);
                end
            end else if (state == SHUFFLE) begin
                lfsr <= lfsr_step;
                if (r <= i) begin
                    slots[i] <= slots[r];
                    slots[r] <= slots[i];
                end
                if (advance) begin
                    i   <= i - IDXW'(1);
                    rej <= '0;
                end else begin
                    rej <= rej + REJW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_card_deck_shuffler.sv
// Directed self-checking bench for card_deck_shuffler with a behavioural shuffle model.
`timescale 1ns/10ps
module tb_card_deck_shuffler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed_in = '0;
    logic        busy;
    logic        done;
    logic [3:0]  rd_idx = '0;
    logic [2:0]  rd_symbol;

    int checks = 0;
    int errors = 0;

    card_deck_shuffler #(
        .NCARDS(16), .IDXW(4), .SYMW(3), .LFSR_SEED(16'hACE1), .MAX_REJ(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_in(seed_in),
        .busy(busy), .done(done), .rd_idx(rd_idx), .rd_symbol(rd_symbol)
    );

    always #5 clk = ~clk;

    task automatic model_run(input logic [15:0] seed, output logic [47:0] lay, output int cyc);
        logic [15:0] l;
        logic [2:0]  t;
        int          pos, rj, rv;
        bit          step;
        l = seed ^ 16'hACE1;
        if (l == 16'h0000) l = 16'hACE1;
        for (int k = 0; k < 16; k++) lay[k*3 +: 3] = 3'(k / 2);
        pos = 15; rj = 0; cyc = 0;
        forever begin
            rv = int'(l[3:0]);
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
            cyc++;
            step = 1'b0;
            if (rv <= pos) begin
                t = lay[pos*3 +: 3];
                lay[pos*3 +: 3] = lay[rv*3 +: 3];
                lay[rv*3 +: 3] = t;
                step = 1'b1;
            end else if (rj < 7) begin
                rj++;
            end else begin
                step = 1'b1;
            end
            if (step) begin
                if (pos == 1) break;
                pos--; rj = 0;
            end
        end
    endtask

    task automatic do_start(input logic [15:0] s);
        @(negedge clk);
        seed_in = s;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_layout(output logic [47:0] lay);
        for (int k = 0; k < 16; k++) begin
            rd_idx = 4'(k);
            #0.2;
            lay[k*3 +: 3] = rd_symbol;
        end
    endtask

    task automatic check_run(input string name, input logic [15:0] s, input int n, input logic [47:0] lay);
        logic [47:0] exp_lay;
        int          exp_cyc;
        model_run(s, exp_lay, exp_cyc);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %b want 1 (n=%0d)", name, done, n);
        end
        checks++;
        if (n != 16 + exp_cyc) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, n, 16 + exp_cyc);
        end
        checks++;
        if (lay !== exp_lay) begin
            errors++;
            $display("FAIL %s layout: got %h want %h", name, lay, exp_lay);
        end
    endtask

    task automatic test_reset;
        logic [47:0] lay;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        read_layout(lay);
        checks++;
        if (lay !== 48'h0) begin
            errors++;
            $display("FAIL reset_slots: got %h want 0", lay);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill;
        logic [47:0] lay, exp_lay;
        int n;
        do_start(16'h0001);
        checks++;
        if (dut.lfsr !== 16'hACE0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_seed: got lfsr=%h busy=%b want ace0 1", dut.lfsr, busy);
        end
        repeat (16) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 16; k++) exp_lay[k*3 +: 3] = 3'(k / 2);
        read_layout(lay);
        checks++;
        if (lay !== exp_lay) begin
            errors++;
            $display("FAIL fill_slots: got %h want %h", lay, exp_lay);
        end
        @(negedge clk);
        wait_done(n);
        read_layout(lay);
        // 16 FILL cycles already elapsed, plus the one sampled negedge
        check_run("fill_run", 16'h0001, n + 17, lay);
    endtask

    task automatic test_pairs;
        logic [47:0] lay;
        logic [15:0] s;
        int n;
        int cnt [8];
        bit bad;
        for (int run = 0; run < 64; run++) begin
            s = 16'($urandom);
            do_start(s);
            wait_done(n);
            read_layout(lay);
            check_run("pairs_run", s, n, lay);
            foreach (cnt[c]) cnt[c] = 0;
            for (int k = 0; k < 16; k++) cnt[lay[k*3 +: 3]]++;
            bad = 1'b0;
            foreach (cnt[c]) if (cnt[c] != 2) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL pairs_invariant: seed=%h layout %h not 2 of each code", s, lay);
            end
            checks++;
            if (n < 31 || n > 136) begin
                errors++;
                $display("FAIL pairs_busy_span: got %0d want 31..136", n);
            end
        end
    endtask

    task automatic test_zero_seed;
        logic [47:0] lay1, lay2;
        int n1, n2;
        do_start(16'hACE1);
        checks++;
        if (dut.lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL zero_seed_lfsr: got %h want ace1", dut.lfsr);
        end
        wait_done(n1);
        read_layout(lay1);
        check_run("zero_seed_a", 16'hACE1, n1, lay1);
        do_start(16'hACE1);
        wait_done(n2);
        read_layout(lay2);
        check_run("zero_seed_b", 16'hACE1, n2, lay2);
    endtask

    task automatic test_back_to_back;
        logic [47:0] lay;
        int n;
        do_start(16'h5A5A);
        n = 0;
        seed_in = 16'hFFFF;
        while (busy === 1'b1 && n < 400) begin
            start = (n == 3 || n == 25);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        read_layout(lay);
        check_run("ignore_start", 16'h5A5A, n, lay);
        @(negedge clk);
        seed_in = 16'h0777;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_flags: got done=%b busy=%b want 0 1", done, busy);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        read_layout(lay);
        check_run("restart_run", 16'h0777, n, lay);
    endtask

    task automatic test_mid_reset;
        logic [47:0] lay;
        int n;
        do_start(16'h1234);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dut.lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL midreset_state: got busy=%b done=%b lfsr=%h want 0 0 ace1", busy, done, dut.lfsr);
        end
        read_layout(lay);
        checks++;
        if (lay !== 48'h0) begin
            errors++;
            $display("FAIL midreset_slots: got %h want 0", lay);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start(16'h1234);
        wait_done(n);
        read_layout(lay);
        check_run("midreset_run", 16'h1234, n, lay);
    endtask

    initial begin
        test_reset;
        test_fill;
        test_pairs;
        test_zero_seed;
        test_back_to_back;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
